// File: rtl/riscv_mux_unit_if.sv
// Signal bundle for the riscv_mux_unit selector pair: mux inputs, selects,
// the register-load enable and both combinational and registered results.
interface riscv_mux_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] a3;
    logic [WIDTH-1:0] b3;
    logic [WIDTH-1:0] c3;
    logic [1:0]       s3;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] d_q;

    // Producer side: supplies data/selects, observes results.
    modport master (
        output en, a, b, s, a3, b3, c3, s3,
        input  c, d, c_q, d_q
    );

    // Mux unit side.
    modport slave (
        input  en, a, b, s, a3, b3, c3, s3,
        output c, d, c_q, d_q
    );
endinterface

// File: rtl/riscv_mux_unit.sv
// 2:1 and 3:1 datapath selectors with combinational results and
// enable-gated registered copies for next-stage consumers.
module riscv_mux_unit #(
    parameter int unsigned           WIDTH     = 32,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input logic              clk,
    input logic              rst,
    riscv_mux_unit_if.slave  bus
);

    logic [WIDTH-1:0] c_val;
    logic [WIDTH-1:0] d_val;
    logic [WIDTH-1:0] c_hold_d, c_hold_q;
    logic [WIDTH-1:0] d_hold_d, d_hold_q;

    always_comb begin
        c_val = bus.a;
        if (bus.s) begin
            c_val = bus.b;
        end
    end

    // Encoding 2'b11 is reserved and drives zero so no select value is left open.
    always_comb begin
        d_val = '0;
        case (bus.s3)
            2'b00:   d_val = bus.a3;
            2'b01:   d_val = bus.b3;
            2'b10:   d_val = bus.c3;
            default: d_val = '0;
        endcase
    end

    always_comb begin
        c_hold_d = c_hold_q;
        d_hold_d = d_hold_q;
        if (bus.en) begin
            c_hold_d = c_val;
            d_hold_d = d_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_hold_q <= RESET_VAL;
            d_hold_q <= RESET_VAL;
        end else begin
            c_hold_q <= c_hold_d;
            d_hold_q <= d_hold_d;
        end
    end

    assign bus.c   = c_val;
    assign bus.d   = d_val;
    assign bus.c_q = c_hold_q;
    assign bus.d_q = d_hold_q;

endmodule

// File: tb/tb_riscv_mux_unit.sv
// Self-checking bench for riscv_mux_unit: directed vector table, reset/enable
// sequences and randomized traffic against an array-lookup reference model.
module tb_riscv_mux_unit;

    localparam int unsigned WIDTH = 32;

    logic clk;
    logic rst;

    riscv_mux_unit_if #(.WIDTH(WIDTH)) bus ();

    riscv_mux_unit #(
        .WIDTH     (WIDTH),
        .RESET_VAL ('0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             s;
        logic [WIDTH-1:0] a3;
        logic [WIDTH-1:0] b3;
        logic [WIDTH-1:0] c3;
        logic [1:0]       s3;
        logic [WIDTH-1:0] exp_c;
        logic [WIDTH-1:0] exp_d;
    } vec_t;

    vec_t vecs [6];

    logic [WIDTH-1:0] exp_cq;
    logic [WIDTH-1:0] exp_dq;

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: look the result up in a table of candidate sources.
    function automatic logic [WIDTH-1:0] ref_c(input logic [WIDTH-1:0] x0,
                                               input logic [WIDTH-1:0] x1,
                                               input logic sel);
        logic [WIDTH-1:0] opts [2];
        opts[0] = x0;
        opts[1] = x1;
        return opts[sel];
    endfunction

    function automatic logic [WIDTH-1:0] ref_d(input logic [WIDTH-1:0] x0,
                                               input logic [WIDTH-1:0] x1,
                                               input logic [WIDTH-1:0] x2,
                                               input logic [1:0] sel);
        logic [WIDTH-1:0] opts [4];
        opts[0] = x0;
        opts[1] = x1;
        opts[2] = x2;
        opts[3] = '0;
        return opts[sel];
    endfunction

    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                         input logic [WIDTH-1:0] a3, input logic [WIDTH-1:0] b3,
                         input logic [WIDTH-1:0] c3, input logic [1:0] s3);
        bus.a  = a;
        bus.b  = b;
        bus.s  = s;
        bus.a3 = a3;
        bus.b3 = b3;
        bus.c3 = c3;
        bus.s3 = s3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic             r_en;
        logic             r_s;
        logic [1:0]       r_s3;
        logic [WIDTH-1:0] r_a, r_b, r_a3, r_b3, r_c3;

        vecs[0] = '{32'hA, 32'hB, 1'b0, 32'hA, 32'hB, 32'hC, 2'b00, 32'hA, 32'hA};
        vecs[1] = '{32'hA, 32'hB, 1'b1, 32'hA, 32'hB, 32'hC, 2'b01, 32'hB, 32'hB};
        vecs[2] = '{32'hA, 32'hB, 1'b1, 32'hA, 32'hB, 32'hC, 2'b10, 32'hB, 32'hC};
        vecs[3] = '{32'hA, 32'hB, 1'b0, 32'hA, 32'hB, 32'hC, 2'b11, 32'hA, 32'h0};
        vecs[4] = '{32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678,
                    32'hFFFF_FFFF, 2'b10, 32'h8000_0001, 32'hFFFF_FFFF};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0, 32'hCAFE_F00D,
                    32'h1, 2'b11, 32'hFFFF_FFFF, 32'h0};

        rst    = 1'b0;
        bus.en = 1'b0;
        drive('0, '0, 1'b0, '0, '0, '0, 2'b00);

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        chk("reset_c_q", bus.c_q, '0);
        chk("reset_d_q", bus.d_q, '0);

        // Directed selection table; no clock involvement needed.
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].a3, vecs[i].b3, vecs[i].c3,
                  vecs[i].s3);
            #1;
            chk($sformatf("vec%0d_c", i), bus.c, vecs[i].exp_c);
            chk($sformatf("vec%0d_d", i), bus.d, vecs[i].exp_d);
        end

        // Capture after release, then reset mid-operation.
        bus.en = 1'b1;
        drive(32'hA, 32'hB, 1'b1, 32'hA, 32'hB, 32'hC, 2'b10);
        repeat (2) @(posedge clk);
        #1;
        chk("held_in_reset_c_q", bus.c_q, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_cap_c_q", bus.c_q, 32'hB);
        chk("first_cap_d_q", bus.d_q, 32'hC);

        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_c_q", bus.c_q, '0);
        chk("mid_rst_d_q", bus.d_q, '0);
        chk("mid_rst_c", bus.c, 32'hB);
        chk("mid_rst_d", bus.d, 32'hC);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst_hold_c_q", bus.c_q, '0);
            chk("rst_hold_d_q", bus.d_q, '0);
        end

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("pre_edge_c_q", bus.c_q, '0);
        chk("pre_edge_d_q", bus.d_q, '0);
        @(posedge clk);
        #1;
        chk("cap_c_q", bus.c_q, 32'hB);
        chk("cap_d_q", bus.d_q, 32'hC);

        // Enable hold.
        @(negedge clk);
        bus.en = 1'b0;
        bus.s  = 1'b0;
        bus.s3 = 2'b00;
        #1;
        chk("hold_c", bus.c, 32'hA);
        chk("hold_d", bus.d, 32'hA);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("hold_c_q", bus.c_q, 32'hB);
            chk("hold_d_q", bus.d_q, 32'hC);
        end
        @(negedge clk);
        bus.en = 1'b1;
        @(posedge clk);
        #1;
        chk("reen_c_q", bus.c_q, 32'hA);
        chk("reen_d_q", bus.d_q, 32'hA);

        // Pending capture discarded when reset spans the edge.
        @(negedge clk);
        bus.s  = 1'b1;
        bus.s3 = 2'b01;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        chk("discard_c_q", bus.c_q, '0);
        chk("discard_d_q", bus.d_q, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("recap_c_q", bus.c_q, 32'hB);
        chk("recap_d_q", bus.d_q, 32'hB);

        // Randomized traffic against the reference model.
        exp_cq = 32'hB;
        exp_dq = 32'hB;
        for (int i = 0; i < 1000; i++) begin
            r_a  = $urandom;
            r_b  = $urandom;
            r_a3 = $urandom;
            r_b3 = $urandom;
            r_c3 = $urandom;
            r_s  = 1'($urandom_range(0, 1));
            r_s3 = 2'($urandom_range(0, 3));
            r_en = ($urandom_range(0, 3) != 0);
            drive(r_a, r_b, r_s, r_a3, r_b3, r_c3, r_s3);
            bus.en = r_en;
            #1;
            chk("rand_c", bus.c, ref_c(r_a, r_b, r_s));
            chk("rand_d", bus.d, ref_d(r_a3, r_b3, r_c3, r_s3));
            if (r_en) begin
                exp_cq = ref_c(r_a, r_b, r_s);
                exp_dq = ref_d(r_a3, r_b3, r_c3, r_s3);
            end
            @(posedge clk);
            #1;
            chk("rand_c_q", bus.c_q, exp_cq);
            chk("rand_d_q", bus.d_q, exp_dq);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
